shift_normalizer: RTL and testbench

Iterative normalizer that is the inverse companion of the team's 8-bit registered barrel shifter: given a word, it finds and reports the shift amount that brings the first set bit to the MSB (left mode) or the LSB (right mode). It also returns the normalized word. It shifts one bit per clock under a start/busy/done handshake. It sits downstream of the shifter, in datapaths and benches, to recover `Shift_Amount` from shifted data.

---
 rtl/shift_normalizer.sv | 84 ++++++++
 tb/tb_shift_normalizer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts one bit per clock until the first set bit reaches
// the MSB (left) or LSB (right), reporting the normalized word and shift count.
module shift_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Direction,
  input  logic [WIDTH-1:0] Data_In,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Data_Out,
  output logic [CNT_W-1:0] Shift_Count,
  output logic             Zero
);

  // state   | meaning
  // IDLE    | waiting for Start
  // SHIFT   | shifting working register toward the target end
  // DONE_ST | one-cycle result-valid pulse
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             target_bit;

  assign target_bit = dir ? work[0] : work[WIDTH-1];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      work        <= '0;
      count       <= '0;
      dir         <= 1'b0;
      Data_Out    <= '0;
      Shift_Count <= '0;
      Zero        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            work  <= Data_In;
            dir   <= Direction;
            count <= '0;
            if (Data_In == '0) begin
              state       <= DONE_ST;
              Data_Out    <= '0;
              Shift_Count <= '0;
              Zero        <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (target_bit) begin
            state       <= DONE_ST;
            Data_Out    <= work;
            Shift_Count <= count;
            Zero        <= 1'b0;
          end else begin
            // Logical shift; a nonzero operand terminates before count can wrap.
            work  <= dir ? (work >> 1) : (work << 1);
            count <= count + CNT_ONE;
          end
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE_ST);

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed-vector bench for shift_normalizer: table of operations plus
// handshake and reset-abort sequences.
module tb_shift_normalizer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Direction;
  logic [7:0] Data_In;
  logic       Busy;
  logic       Done;
  logic [7:0] Data_Out;
  logic [2:0] Shift_Count;
  logic       Zero;

  int passed = 0;
  int total  = 0;

  logic [7:0] prev_out  = 8'h00;
  logic [2:0] prev_cnt  = 3'd0;
  logic       prev_zero = 1'b0;

  shift_normalizer #(.WIDTH(8), .CNT_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Direction(Direction),
    .Data_In(Data_In), .Busy(Busy), .Done(Done), .Data_Out(Data_Out),
    .Shift_Count(Shift_Count), .Zero(Zero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       dir;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [2:0] exp_cnt;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Assumes it is called just after a negedge; returns just after a negedge.
  task automatic run_op(input string name, input vec_t v);
    int n;
    int busy_cnt;
    int exp_n;
    bit got;
    bit held_ok;
    n = 0; busy_cnt = 0; got = 0; held_ok = 1;
    exp_n = v.exp_zero ? 1 : int'(v.exp_cnt) + 2;
    Start = 1'b1; Direction = v.dir; Data_In = v.din;
    @(posedge Clock);
    #1;
    Start = 1'b0; Direction = ~v.dir; Data_In = ~v.din;
    while (!got && n < 20) begin
      @(negedge Clock);
      n++;
      if (Busy) busy_cnt++;
      if (Done) got = 1;
      else if (Data_Out !== prev_out || Shift_Count !== prev_cnt || Zero !== prev_zero)
        held_ok = 0;
    end
    check({name, " done_latency"}, n, exp_n);
    check({name, " busy_cycles"}, busy_cnt, exp_n);
    check({name, " data_out"}, int'(Data_Out), int'(v.exp_out));
    check({name, " shift_count"}, int'(Shift_Count), int'(v.exp_cnt));
    check({name, " zero"}, int'(Zero), int'(v.exp_zero));
    check({name, " outputs_held"}, int'(held_ok), 1);
    @(negedge Clock);
    check({name, " idle_after"}, int'({Busy, Done}), 0);
    prev_out = v.exp_out; prev_cnt = v.exp_cnt; prev_zero = v.exp_zero;
  endtask

  initial begin
    int n;
    bit got;
    bit saw_done;

    vecs[0] = '{1'b0, 8'h13, 8'h98, 3'd3, 1'b0};
    vecs[1] = '{1'b1, 8'hA0, 8'h05, 3'd5, 1'b0};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 3'd0, 1'b0};
    vecs[3] = '{1'b0, 8'h01, 8'h80, 3'd7, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1};
    vecs[5] = '{1'b0, 8'h02, 8'h80, 3'd6, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0};
    vecs[7] = '{1'b1, 8'h80, 8'h01, 3'd7, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b1};

    Reset = 1'b1; Start = 1'b0; Direction = 1'b0; Data_In = 8'h00;
    repeat (3) @(negedge Clock);
    check("reset_outputs", int'({Busy, Done, Data_Out, Shift_Count, Zero}), 0);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Start held high across SHIFT and DONE; Data_In changes mid-operation.
    Start = 1'b1; Direction = 1'b0; Data_In = 8'h13;
    @(posedge Clock);
    #1 Data_In = 8'h40;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge Clock);
      n++;
      if (Done) got = 1;
    end
    check("hs1 latency", n, 5);
    check("hs1 data_out", int'(Data_Out), 8'h98);
    check("hs1 shift_count", int'(Shift_Count), 3);
    @(negedge Clock);
    check("hs idle_after_done", int'(Busy), 0);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge Clock);
      n++;
      if (Done) got = 1;
    end
    Start = 1'b0;
    check("hs2 latency", n, 3);
    check("hs2 data_out", int'(Data_Out), 8'h80);
    check("hs2 shift_count", int'(Shift_Count), 1);
    @(negedge Clock);

    // Reset at E2 of a left normalize of 8'h01, with Start asserted alongside.
    Start = 1'b1; Direction = 1'b0; Data_In = 8'h01;
    @(posedge Clock);
    #1 Start = 1'b0;
    @(negedge Clock);
    check("rst busy_before", int'(Busy), 1);
    Reset = 1'b1; Start = 1'b1;
    @(negedge Clock);
    check("rst abort_outputs", int'({Busy, Done, Data_Out, Shift_Count, Zero}), 0);
    @(negedge Clock);
    check("rst start_ignored", int'(Busy), 0);
    Reset = 1'b0; Start = 1'b0;
    saw_done = 0;
    repeat (12) begin
      @(negedge Clock);
      if (Done || Busy) saw_done = 1;
    end
    check("rst no_done", int'(saw_done), 0);
    prev_out = 8'h00; prev_cnt = 3'd0; prev_zero = 1'b0;

    run_op("after_reset", vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
